// File: rtl/keystream_xor_ctrl_pkg.sv
// Shared types and constants for the ChaCha20 keystream XOR sequencing controller.
package keystream_xor_pkg;

  // Bytes produced by one ChaCha20 block.
  localparam int BLOCK_BYTES = 64;

  // Width of the ChaCha20 block counter.
  localparam int CTR_W = 32;

  // Controller states, visible on the debug port.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FIRE = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5,
    FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/keystream_xor_ctrl_if.sv
// Bundle of job-control, keystream, plaintext and ciphertext signals around the
// keystream XOR controller.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and ready
// are high. A source holds valid and its payload stable until that edge and never
// waits for ready before raising valid; a sink may raise or drop ready at will.
// ks_req/ks_done, start/done and xor_ready are single-cycle pulses, not handshakes.
interface keystream_xor_ctrl_if #(
  parameter int LEN_W  = 32,
  parameter int NO_REG = 192
);
  import keystream_xor_pkg::*;

  // Job control from / to the AEAD sequencer.
  logic                       start;
  logic [LEN_W-1:0]           msg_len;
  logic [CTR_W-1:0]           init_counter;
  logic                       busy;
  logic                       done;
  logic                       err;

  // ChaCha20 block core.
  logic                       ks_req;
  logic [CTR_W-1:0]           ks_counter;
  logic                       ks_done;

  // Plaintext chunk input.
  logic                       pt_valid;
  logic                       pt_ready;

  // XOR stage enable and ciphertext chunk output.
  logic                       xor_ready;
  logic                       ct_valid;
  logic                       ct_ready;
  logic [$clog2(NO_REG+1)-1:0] ct_bytes;
  logic                       ct_last;

  // Controller side.
  modport master (
    input  start, msg_len, init_counter, ks_done, pt_valid, ct_ready,
    output busy, done, err, ks_req, ks_counter, pt_ready, xor_ready,
           ct_valid, ct_bytes, ct_last
  );

  // Surrounding blocks (sequencer, core, datapath, downstream sink).
  modport slave (
    output start, msg_len, init_counter, ks_done, pt_valid, ct_ready,
    input  busy, done, err, ks_req, ks_counter, pt_ready, xor_ready,
           ct_valid, ct_bytes, ct_last
  );

endinterface

// File: rtl/keystream_xor_ctrl.sv
// Sequencing controller for the ChaCha20 keystream XOR stage: splits a message
// into NO_REG-byte batches, requests keystream, collects plaintext, pulses the
// XOR enable and presents each ciphertext chunk downstream.
module keystream_xor_ctrl
  import keystream_xor_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int NUM_MATRICES = 3,
  parameter int NO_REG       = 64 * NUM_MATRICES,
  parameter int LEN_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  keystream_xor_ctrl_if.master  bus,
  output state_t                dbg_state
);

  localparam int BYTES_W = $clog2(NO_REG + 1);
  // Wide enough that counter + block count can never wrap.
  localparam int SUM_W   = ((LEN_W > CTR_W) ? LEN_W : CTR_W) + 2;
  localparam logic [SUM_W-1:0] CTR_MAX = (SUM_W'(1) << CTR_W) - SUM_W'(1);

  // Batch geometry and the datapath width must agree with the XOR stage.
  if ((NO_REG != BLOCK_BYTES * NUM_MATRICES) || (DATA_SIZE < 1)) begin : g_param_check
    $error("keystream_xor_ctrl: inconsistent NO_REG/NUM_MATRICES/DATA_SIZE");
  end

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [CTR_W-1:0]   counter;
  logic               ks_got;
  logic               pt_got;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               ks_req_q;
  logic               xor_q;
  logic               ct_valid_q;
  logic [BYTES_W-1:0] ct_bytes_q;
  logic               ct_last_q;

  logic [SUM_W-1:0]   blocks;
  logic [SUM_W-1:0]   last_ctr;
  logic               ctr_ovf;
  logic [BYTES_W-1:0] chunk_bytes;
  logic               chunk_last;
  logic               ks_now;
  logic               pt_now;

  // Start check: the last block counter of the job must still fit in CTR_W bits.
  always_comb begin
    blocks   = (SUM_W'(bus.msg_len) + SUM_W'(BLOCK_BYTES - 1)) >> $clog2(BLOCK_BYTES);
    last_ctr = SUM_W'(bus.init_counter) + blocks - SUM_W'(1);
    ctr_ovf  = (last_ctr > CTR_MAX);
  end

  // Size of the current batch and whether it closes the message.
  always_comb begin
    chunk_last  = (remaining <= LEN_W'(NO_REG));
    chunk_bytes = chunk_last ? remaining[BYTES_W-1:0] : BYTES_W'(NO_REG);
    ks_now      = ks_got | bus.ks_done;
    pt_now      = pt_got | bus.pt_valid;
  end

  // Main sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      counter    <= '0;
      ks_got     <= 1'b0;
      pt_got     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ks_req_q   <= 1'b0;
      xor_q      <= 1'b0;
      ct_valid_q <= 1'b0;
      ct_bytes_q <= '0;
      ct_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.msg_len == '0) begin
              err_q <= 1'b0;
              state <= FIN;
            end else if (ctr_ovf) begin
              err_q <= 1'b1;
              state <= FIN;
            end else begin
              err_q     <= 1'b0;
              remaining <= bus.msg_len;
              counter   <= bus.init_counter;
              ks_req_q  <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          ks_req_q <= 1'b0;
          ks_got   <= 1'b0;
          pt_got   <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          // Keystream and plaintext arrive independently, in any order.
          if (ks_now && pt_now) begin
            ks_got <= 1'b0;
            pt_got <= 1'b0;
            xor_q  <= 1'b1;
            state  <= FIRE;
          end else begin
            ks_got <= ks_now;
            pt_got <= pt_now;
          end
        end
        FIRE: begin
          xor_q      <= 1'b0;
          ct_bytes_q <= chunk_bytes;
          ct_last_q  <= chunk_last;
          state      <= CAP;
        end
        CAP: begin
          ct_valid_q <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (bus.ct_ready) begin
            ct_valid_q <= 1'b0;
            remaining  <= remaining - LEN_W'(ct_bytes_q);
            counter    <= counter + CTR_W'(NUM_MATRICES);
            if (ct_last_q) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= FIN;
            end else begin
              ks_req_q <= 1'b1;
              state    <= REQ;
            end
          end
        end
        FIN: begin
          // Zero-length and error jobs arrive here with done still low.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.ks_req     = ks_req_q;
  assign bus.ks_counter = counter;
  assign bus.pt_ready   = (state == WAIT) && !pt_got;
  assign bus.xor_ready  = xor_q;
  assign bus.ct_valid   = ct_valid_q;
  assign bus.ct_bytes   = ct_bytes_q;
  assign bus.ct_last    = ct_last_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_keystream_xor_ctrl.sv
// Directed bench for keystream_xor_ctrl: hand-computed batch counters, chunk
// sizes, pulse timing, counter-overflow boundary and mid-job reset.
module tb_keystream_xor_ctrl;
  import keystream_xor_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;

  int n_ksreq = 0;
  int n_xor   = 0;
  int n_ct    = 0;
  int n_done  = 0;

  keystream_xor_ctrl_if #(.LEN_W(32), .NO_REG(192)) bus ();

  keystream_xor_ctrl #(
    .DATA_SIZE(8), .NUM_MATRICES(3), .NO_REG(192), .LEN_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock and event monitor.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ks_req) n_ksreq++;
    if (bus.xor_ready) n_xor++;
    if (bus.ct_valid && bus.ct_ready) n_ct++;
    if (bus.done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ":state"}, 64'(dbg_state), 64'(IDLE));
    chk({tag, ":busy"}, 64'(bus.busy), 64'(0));
    chk({tag, ":ks_req"}, 64'(bus.ks_req), 64'(0));
    chk({tag, ":xor"}, 64'(bus.xor_ready), 64'(0));
    chk({tag, ":ct_valid"}, 64'(bus.ct_valid), 64'(0));
    chk({tag, ":ct_last"}, 64'(bus.ct_last), 64'(0));
    chk({tag, ":ct_bytes"}, 64'(bus.ct_bytes), 64'(0));
    chk({tag, ":done"}, 64'(bus.done), 64'(0));
    chk({tag, ":err"}, 64'(bus.err), 64'(0));
    chk({tag, ":ks_counter"}, 64'(bus.ks_counter), 64'(0));
    chk({tag, ":pt_ready"}, 64'(bus.pt_ready), 64'(0));
  endtask

  task automatic start_job(input logic [31:0] len, input logic [31:0] ctr);
    bus.start        = 1'b1;
    bus.msg_len      = len;
    bus.init_counter = ctr;
    tick();
    bus.start = 1'b0;
  endtask

  // Runs one batch starting in its REQ cycle. Plaintext arrives pt_dly cycles and
  // ks_done ks_dly cycles into WAIT; downstream stalls for hold cycles.
  task automatic batch(input string tag, input logic [31:0] exp_ctr, input int exp_bytes,
                       input logic exp_last, input int pt_dly, input int ks_dly, input int hold);
    int last_ev;
    bit pt_acc;
    chk({tag, ":ks_req"}, 64'(bus.ks_req), 64'(1));
    chk({tag, ":ks_counter"}, 64'(bus.ks_counter), 64'(exp_ctr));
    chk({tag, ":busy"}, 64'(bus.busy), 64'(1));
    tick();
    last_ev = (pt_dly > ks_dly) ? pt_dly : ks_dly;
    pt_acc  = 1'b0;
    for (int c = 0; c <= last_ev; c++) begin
      bus.pt_valid = (c >= pt_dly) && !pt_acc;
      bus.ks_done  = (c == ks_dly);
      if (c == pt_dly) begin
        chk({tag, ":pt_ready"}, 64'(bus.pt_ready), 64'(1));
        pt_acc = 1'b1;
      end
      chk({tag, ":xor_early"}, 64'(bus.xor_ready), 64'(0));
      chk({tag, ":ks_req_wait"}, 64'(bus.ks_req), 64'(0));
      tick();
    end
    bus.pt_valid = 1'b0;
    bus.ks_done  = 1'b0;
    chk({tag, ":xor"}, 64'(bus.xor_ready), 64'(1));
    chk({tag, ":pt_ready_fire"}, 64'(bus.pt_ready), 64'(0));
    tick();
    chk({tag, ":xor_off"}, 64'(bus.xor_ready), 64'(0));
    chk({tag, ":ct_valid_cap"}, 64'(bus.ct_valid), 64'(0));
    tick();
    chk({tag, ":ct_valid"}, 64'(bus.ct_valid), 64'(1));
    chk({tag, ":ct_bytes"}, 64'(bus.ct_bytes), 64'(exp_bytes));
    chk({tag, ":ct_last"}, 64'(bus.ct_last), 64'(exp_last));
    for (int h = 0; h < hold; h++) begin
      bus.ct_ready = 1'b0;
      // Inputs that must be ignored while a chunk waits downstream.
      bus.ks_done  = (h == 2);
      bus.start    = (h == 4);
      bus.msg_len  = 32'd0;
      bus.pt_valid = (h == 6);
      tick();
      bus.ks_done  = 1'b0;
      bus.start    = 1'b0;
      bus.pt_valid = 1'b0;
      chk({tag, ":hold_valid"}, 64'(bus.ct_valid), 64'(1));
      chk({tag, ":hold_bytes"}, 64'(bus.ct_bytes), 64'(exp_bytes));
      chk({tag, ":hold_last"}, 64'(bus.ct_last), 64'(exp_last));
      chk({tag, ":hold_ks_req"}, 64'(bus.ks_req), 64'(0));
      chk({tag, ":hold_pt_ready"}, 64'(bus.pt_ready), 64'(0));
    end
    bus.ct_ready = 1'b1;
    tick();
    bus.ct_ready = 1'b0;
    chk({tag, ":ct_valid_drop"}, 64'(bus.ct_valid), 64'(0));
    if (exp_last) begin
      chk({tag, ":done"}, 64'(bus.done), 64'(1));
      chk({tag, ":busy_fall"}, 64'(bus.busy), 64'(0));
      chk({tag, ":ks_req_end"}, 64'(bus.ks_req), 64'(0));
      tick();
      chk({tag, ":done_off"}, 64'(bus.done), 64'(0));
      chk({tag, ":idle"}, 64'(dbg_state), 64'(IDLE));
    end else begin
      chk({tag, ":next_req"}, 64'(dbg_state), 64'(REQ));
    end
  endtask

  // Directed sequence.
  initial begin
    int b_ks, b_xor, b_ct, b_done;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.msg_len      = '0;
    bus.init_counter = '0;
    bus.ks_done      = 1'b0;
    bus.pt_valid     = 1'b0;
    bus.ct_ready     = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // 192 bytes from counter 1: single full batch.
    b_ks = n_ksreq; b_xor = n_xor; b_ct = n_ct; b_done = n_done;
    start_job(32'd192, 32'd1);
    chk("a:err", 64'(bus.err), 64'(0));
    batch("a0", 32'd1, 192, 1'b1, 0, 2, 0);
    chk("a:n_ksreq", 64'(n_ksreq - b_ks), 64'(1));
    chk("a:n_xor", 64'(n_xor - b_xor), 64'(1));
    chk("a:n_ct", 64'(n_ct - b_ct), 64'(1));
    chk("a:n_done", 64'(n_done - b_done), 64'(1));
    chk("a:err_end", 64'(bus.err), 64'(0));

    // 400 bytes from counter 1: 192 + 192 + 16, counters 1, 4, 7.
    b_ks = n_ksreq; b_xor = n_xor; b_ct = n_ct; b_done = n_done;
    start_job(32'd400, 32'd1);
    batch("b0", 32'd1, 192, 1'b0, 1, 0, 0);
    batch("b1", 32'd4, 192, 1'b0, 0, 0, 0);
    batch("b2", 32'd7, 16, 1'b1, 0, 3, 0);
    chk("b:n_ksreq", 64'(n_ksreq - b_ks), 64'(3));
    chk("b:n_xor", 64'(n_xor - b_xor), 64'(3));
    chk("b:n_ct", 64'(n_ct - b_ct), 64'(3));
    chk("b:n_done", 64'(n_done - b_done), 64'(1));

    // Zero-length job: done two cycles after start, nothing else.
    b_ks = n_ksreq; b_ct = n_ct;
    start_job(32'd0, 32'd5);
    chk("z:busy", 64'(bus.busy), 64'(1));
    chk("z:done_early", 64'(bus.done), 64'(0));
    chk("z:ks_req", 64'(bus.ks_req), 64'(0));
    tick();
    chk("z:done", 64'(bus.done), 64'(1));
    chk("z:busy_fall", 64'(bus.busy), 64'(0));
    tick();
    chk("z:done_off", 64'(bus.done), 64'(0));
    chk("z:idle", 64'(dbg_state), 64'(IDLE));
    chk("z:n_ksreq", 64'(n_ksreq - b_ks), 64'(0));
    chk("z:n_ct", 64'(n_ct - b_ct), 64'(0));

    // Counter overflow: 0xFFFFFFFE + 3 blocks - 1 exceeds 32 bits.
    b_ks = n_ksreq; b_ct = n_ct;
    start_job(32'd192, 32'hFFFF_FFFE);
    chk("o:err", 64'(bus.err), 64'(1));
    chk("o:ks_req", 64'(bus.ks_req), 64'(0));
    chk("o:done_early", 64'(bus.done), 64'(0));
    tick();
    chk("o:done", 64'(bus.done), 64'(1));
    chk("o:err_hold", 64'(bus.err), 64'(1));
    tick();
    chk("o:idle", 64'(dbg_state), 64'(IDLE));
    chk("o:err_sticky", 64'(bus.err), 64'(1));
    chk("o:n_ksreq", 64'(n_ksreq - b_ks), 64'(0));
    chk("o:n_ct", 64'(n_ct - b_ct), 64'(0));

    // Last counter exactly 0xFFFFFFFF: legal, and clears the sticky error.
    start_job(32'd192, 32'hFFFF_FFFD);
    chk("m:err_clr", 64'(bus.err), 64'(0));
    batch("m0", 32'hFFFF_FFFD, 192, 1'b1, 2, 1, 0);
    chk("m:err_end", 64'(bus.err), 64'(0));

    // Handshake ordering and downstream stall, 768 bytes from counter 10.
    b_ks = n_ksreq; b_done = n_done;
    start_job(32'd768, 32'd10);
    batch("h0", 32'd10, 192, 1'b0, 0, 5, 0);
    batch("h1", 32'd13, 192, 1'b0, 5, 0, 10);
    batch("h2", 32'd16, 192, 1'b0, 0, 3, 0);
    batch("h3", 32'd19, 192, 1'b1, 3, 3, 0);
    chk("h:n_ksreq", 64'(n_ksreq - b_ks), 64'(4));
    chk("h:n_done", 64'(n_done - b_done), 64'(1));

    // Reset in WAIT, then a stale ks_done after release.
    start_job(32'd192, 32'd5);
    tick();
    tick();
    chk("r:in_wait", 64'(dbg_state), 64'(WAIT));
    rst_n = 1'b0;
    #1;
    check_idle("r:abort");
    tick();
    rst_n = 1'b1;
    bus.ks_done = 1'b1;
    tick();
    bus.ks_done = 1'b0;
    check_idle("r:late_ks");
    tick();
    check_idle("r:stay");

    // Job after the abort runs cleanly from a fresh counter.
    start_job(32'd64, 32'd2);
    batch("p0", 32'd2, 64, 1'b1, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
